// File: rtl/ps2_cmd_scheduler.sv
// PS/2 command scheduler: arbitrates two requesters onto one tx/rx link, one command in flight,
// with ACK/resend/error handling, multi-byte replies, timeouts, bounded retries and stream pass-through.
// Define PS2_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ps2_cmd_scheduler #(
    parameter int unsigned RESP_TIMEOUT_CYC = 540000,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned GAP_CYC          = 2700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_cmd,
    input  logic [1:0]  req0_nresp,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_cmd,
    input  logic [1:0]  req1_nresp,
    output logic        req1_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        tx_error,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [2:0]  rsp_status,
    output logic [23:0] rsp_data,
    output logic        stream_valid,
    output logic [7:0]  stream_byte,
    output logic        busy
);
    localparam int TW = $clog2(RESP_TIMEOUT_CYC + 2);
    localparam int GW = $clog2(GAP_CYC + 2);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(RESP_TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_DATA, DONE, GAP} state_t;

    state_t         state, state_nxt;
    logic [7:0]     cmd_q, cmd_d;
    logic [1:0]     nresp_q, nresp_d, idx_q, idx_d;
    logic           id_q, id_d, seen_busy_q, seen_busy_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [23:0]    data_q, data_d;
    logic [2:0]     status_q, status_d;
    logic           accept, grant1, rx_taken, retry_req;

`ifdef PS2_RR_ARB_EN
    logic last_q;
    // last-granted port drops to lowest priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_q <= 1'b1;
        else if (accept) last_q <= grant1;
    end
    assign grant1 = req1_valid && (!req0_valid || !last_q);
`else
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign tx_start = (state == SEND);
    assign tx_data  = cmd_q;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        cmd_d       = cmd_q;
        nresp_d     = nresp_q;
        idx_d       = idx_q;
        id_d        = id_q;
        seen_busy_d = seen_busy_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        data_d      = data_q;
        status_d    = status_q;
        accept      = 1'b0;
        rx_taken    = 1'b0;
        retry_req   = 1'b0;
        case (state)
            IDLE: if (req0_valid || req1_valid) begin
                accept    = 1'b1;
                id_d      = grant1;
                cmd_d     = grant1 ? req1_cmd : req0_cmd;
                nresp_d   = grant1 ? req1_nresp : req0_nresp;
                retry_d   = '0;
                data_d    = '0;
                state_nxt = SEND;
            end
            SEND: begin
                timer_d     = TIMEOUT_LD;
                seen_busy_d = 1'b0;
                state_nxt   = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_busy) seen_busy_d = 1'b1;
                else if (seen_busy_q) begin
                    if (tx_error) retry_req = 1'b1;
                    else          state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: if (rx_ready) begin
                rx_taken = 1'b1;
                case (rx_data)
                    8'hFA: begin
                        if (nresp_q == 2'd0) begin
                            status_d  = 3'd0;
                            state_nxt = DONE;
                        end else begin
                            timer_d   = TIMEOUT_LD;
                            idx_d     = 2'd0;
                            state_nxt = WAIT_DATA;
                        end
                    end
                    8'hFE: retry_req = 1'b1;
                    8'hFC: begin
                        status_d  = 3'd1;
                        state_nxt = DONE;
                    end
                    default: rx_taken = 1'b0;
                endcase
            end
            WAIT_DATA: if (rx_ready) begin
                rx_taken = 1'b1;
                data_d   = data_q | ({16'd0, rx_data} << {idx_q, 3'b000});
                timer_d  = TIMEOUT_LD;
                if (idx_q == nresp_q - 2'd1) begin
                    status_d  = 3'd0;
                    state_nxt = DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                gap_d     = GW'(GAP_CYC);
                state_nxt = GAP;
            end
            GAP: begin
                if (gap_q <= GW'(1)) state_nxt = IDLE;
                else                 gap_d = gap_q - GW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        if (retry_req) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d   = retry_q + RW'(1);
                state_nxt = SEND;
            end else begin
                status_d  = 3'd3;
                state_nxt = DONE;
            end
        end

        // a consumed reply byte in the expiry cycle wins over the timeout
        if ((state == WAIT_TX || state == WAIT_ACK || state == WAIT_DATA) && !rx_taken && !retry_req) begin
            if (timer_q <= TW'(1)) begin
                status_d  = 3'd2;
                state_nxt = DONE;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_q        <= '0;
            nresp_q      <= '0;
            idx_q        <= '0;
            id_q         <= 1'b0;
            seen_busy_q  <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            gap_q        <= '0;
            data_q       <= '0;
            status_q     <= '0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_status   <= '0;
            rsp_data     <= '0;
            stream_valid <= 1'b0;
            stream_byte  <= '0;
        end else begin
            state        <= state_nxt;
            cmd_q        <= cmd_d;
            nresp_q      <= nresp_d;
            idx_q        <= idx_d;
            id_q         <= id_d;
            seen_busy_q  <= seen_busy_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            status_q     <= status_d;
            req0_ready   <= accept && !grant1;
            req1_ready   <= accept && grant1;
            rsp_valid    <= (state == DONE);
            if (state == DONE) begin
                rsp_id     <= id_q;
                rsp_status <= status_q;
                rsp_data   <= data_q;
            end
            stream_valid <= rx_ready && !rx_taken;
            if (rx_ready && !rx_taken) stream_byte <= rx_data;
        end
    end
endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Randomized self-checking bench for ps2_cmd_scheduler with a scripted PS/2 device and a
// transaction-level expectation model (attempt counts, status and reply bytes per command).
module tb_ps2_cmd_scheduler;
    localparam int TO  = 300;
    localparam int MR  = 3;
    localparam int GAP = 20;
`ifdef PS2_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [7:0] req0_cmd = 0, req1_cmd = 0;
    logic [1:0] req0_nresp = 0, req1_nresp = 0;
    logic [7:0] tx_data, rx_data = 0, stream_byte;
    logic tx_start, tx_busy = 0, tx_error = 0, rx_ready = 0;
    logic rsp_valid, rsp_id, stream_valid, busy;
    logic [2:0] rsp_status;
    logic [23:0] rsp_data;

    always #5 clk = ~clk;

    ps2_cmd_scheduler #(.RESP_TIMEOUT_CYC(TO), .MAX_RETRY(MR), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_nresp(req0_nresp), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_nresp(req1_nresp), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_error(tx_error),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .stream_valid(stream_valid), .stream_byte(stream_byte), .busy(busy)
    );

    typedef struct {logic id; logic [2:0] st; logic [23:0] d; int c;} rsp_t;

    int checks = 0, errors = 0, cyc = 0;
    int n_starts = 0, start_cyc = 0, bad_tx = 0;
    logic [7:0] cur_cmd = 0;
    bit tb_last = 1'b1;
    rsp_t rsp_q[$];
    logic [7:0] strm_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            n_starts  <= n_starts + 1;
            start_cyc <= cyc;
            if (tx_data !== cur_cmd) bad_tx <= bad_tx + 1;
        end
        if (rsp_valid) rsp_q.push_back('{rsp_id, rsp_status, rsp_data, cyc});
        if (stream_valid) strm_q.push_back(stream_byte);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b; rx_ready = 1'b1; tick(); rx_ready = 1'b0; tick();
    endtask

    task automatic busy_pulse(input bit err);
        tx_error = err; tx_busy = 1'b1; tick(3); tx_busy = 1'b0; tick();
    endtask

    task automatic raise(input bit port, input logic [7:0] cmd, input logic [1:0] nresp, output bit ok);
        ok = 1'b0;
        if (port) begin req1_valid = 1; req1_cmd = cmd; req1_nresp = nresp; end
        else      begin req0_valid = 1; req0_cmd = cmd; req0_nresp = nresp; end
        for (int i = 0; i < 200; i++) begin
            tick();
            if (port ? req1_ready : req0_ready) begin ok = 1'b1; break; end
        end
        if (port) req1_valid = 0; else req0_valid = 0;
        if (ok) tb_last = port;
    endtask

    task automatic wait_starts(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_starts >= k) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_rsp(input int q0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TO + 100; i++) begin
            if (rsp_q.size() > q0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Scripted device: n_retry failed attempts (0xFE or tx_error), then FC or FA + reply bytes.
    task automatic do_cmd(input bit port, input logic [7:0] cmd, input logic [1:0] nresp,
                          input int n_retry, input bit use_err, input bit fc, input logic [23:0] pay,
                          input bit stray, output bit ok, output rsp_t r, output int starts);
        int s0, q0;
        bit w;
        s0 = n_starts; q0 = rsp_q.size(); cur_cmd = cmd; ok = 1'b1;
        raise(port, cmd, nresp, w); ok &= w;
        for (int a = 0; a <= MR && ok; a++) begin
            wait_starts(s0 + a + 1, w); ok &= w;
            if (!w) break;
            if (a < n_retry) begin
                busy_pulse(use_err);
                if (!use_err) begin tick(2); send_rx(8'hFE); end
            end else begin
                busy_pulse(1'b0); tick(2);
                if (stray) send_rx(8'h55);
                if (fc) send_rx(8'hFC);
                else begin
                    send_rx(8'hFA);
                    for (int b = 0; b < int'(nresp); b++) send_rx(pay[8*b +: 8]);
                end
                break;
            end
        end
        wait_rsp(q0, w); ok &= w;
        tx_error = 1'b0;
        if (w) r = rsp_q[q0]; else r = '{1'b0, 3'd7, 24'hDEAD, 0};
        tick(2);
        starts = n_starts - s0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick(3);
        checks++;
        if ({req0_ready, req1_ready, tx_data, tx_start, rsp_valid, rsp_id, rsp_status, rsp_data,
             stream_valid, stream_byte, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        rst_n = 1'b1; tb_last = 1'b1; tick(2);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_basic;
        bit ok; rsp_t r; int st;
        do_cmd(1'b0, 8'hF4, 2'd0, 0, 1'b0, 1'b0, 24'h0, 1'b0, ok, r, st);
        checks++;
        if (!ok || r.id !== 1'b0 || r.st !== 3'd0 || r.d !== 24'h0 || st != 1) begin
            errors++; $display("FAIL cmd_f4: ok=%0b id=%0d st=%0d d=%h starts=%0d want id0 st0 d0 starts1", ok, r.id, r.st, r.d, st);
        end
        do_cmd(1'b0, 8'hFF, 2'd2, 0, 1'b0, 1'b0, 24'h0000AA, 1'b0, ok, r, st);
        checks++;
        if (!ok || r.st !== 3'd0 || r.d !== 24'h0000AA || st != 1) begin
            errors++; $display("FAIL cmd_ff_reply: ok=%0b st=%0d d=%h starts=%0d want st0 d=0000aa", ok, r.st, r.d, st);
        end
    endtask

    task automatic test_retry;
        bit ok; rsp_t r; int st;
        do_cmd(1'b1, 8'hF3, 2'd0, 4, 1'b0, 1'b0, 24'h0, 1'b0, ok, r, st);
        checks++;
        if (!ok || r.id !== 1'b1 || r.st !== 3'd3 || st != MR + 1) begin
            errors++; $display("FAIL retry_exhaust: ok=%0b id=%0d st=%0d starts=%0d want id1 st3 starts%0d", ok, r.id, r.st, st, MR + 1);
        end
        do_cmd(1'b0, 8'hF3, 2'd0, 2, 1'b0, 1'b0, 24'h0, 1'b0, ok, r, st);
        checks++;
        if (!ok || r.st !== 3'd0 || st != 3) begin
            errors++; $display("FAIL retry_recover: ok=%0b st=%0d starts=%0d want st0 starts3", ok, r.st, st);
        end
    endtask

    task automatic test_timeout;
        bit w; rsp_t r; int s0, q0, d;
        s0 = n_starts; q0 = rsp_q.size(); cur_cmd = 8'hF2;
        raise(1'b1, 8'hF2, 2'd1, w);
        if (w) wait_starts(s0 + 1, w);
        if (w) busy_pulse(1'b0);
        wait_rsp(q0, w);
        if (w) r = rsp_q[q0]; else r = '{1'b0, 3'd7, 24'hDEAD, 0};
        d = r.c - start_cyc;
        checks++;
        if (!w || r.id !== 1'b1 || r.st !== 3'd2 || r.d !== 24'h0 || d < TO - 2 || d > TO + 2) begin
            errors++; $display("FAIL timeout: ok=%0b id=%0d st=%0d d=%h delay=%0d want id1 st2 d0 delay %0d+/-2", w, r.id, r.st, r.d, d, TO);
        end
        // timeout after a partial reply keeps the bytes received so far
        s0 = n_starts; q0 = rsp_q.size(); cur_cmd = 8'hE9;
        raise(1'b0, 8'hE9, 2'd3, w);
        if (w) wait_starts(s0 + 1, w);
        if (w) begin busy_pulse(1'b0); send_rx(8'hFA); send_rx(8'h3C); send_rx(8'h5A); end
        wait_rsp(q0, w);
        if (w) r = rsp_q[q0]; else r = '{1'b0, 3'd7, 24'hDEAD, 0};
        checks++;
        if (!w || r.st !== 3'd2 || r.d !== 24'h005A3C) begin
            errors++; $display("FAIL timeout_partial: ok=%0b st=%0d d=%h want st2 d=005a3c", w, r.st, r.d);
        end
        // reply byte landing in the expiry cycle wins
        s0 = n_starts; q0 = rsp_q.size(); cur_cmd = 8'hE6;
        raise(1'b0, 8'hE6, 2'd0, w);
        if (w) wait_starts(s0 + 1, w);
        if (w) begin
            busy_pulse(1'b0);
            while (cyc < start_cyc + TO) tick();
            rx_data = 8'hFA; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        end
        wait_rsp(q0, w);
        if (w) r = rsp_q[q0]; else r = '{1'b0, 3'd7, 24'hDEAD, 0};
        checks++;
        if (!w || r.st !== 3'd0) begin
            errors++; $display("FAIL timeout_coincide: ok=%0b st=%0d want st0", w, r.st);
        end
        tick(GAP + 5);
    endtask

    task automatic test_back_to_back;
        bit w; rsp_t r; int got, exp, q0, s0;
        req0_valid = 1; req0_cmd = 8'h11; req0_nresp = 0;
        req1_valid = 1; req1_cmd = 8'h22; req1_nresp = 0;
        for (int n = 0; n < 5; n++) begin
            if (n == 4) req0_valid = 0;
            exp = (req0_valid && req1_valid) ? (RR ? int'(!tb_last) : 0) : (req1_valid ? 1 : 0);
            q0 = rsp_q.size(); s0 = n_starts; got = -1;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (req0_ready) got = 0; else if (req1_ready) got = 1;
                if (got >= 0) break;
            end
            if (got >= 0) begin
                cur_cmd = (got == 1) ? 8'h22 : 8'h11;
                tb_last = got[0];
            end
            if (n == 4) req1_valid = 0;
            w = (got >= 0);
            if (w) wait_starts(s0 + 1, w);
            if (w) begin busy_pulse(1'b0); tick(2); send_rx(8'hFA); end
            wait_rsp(q0, w);
            if (w) r = rsp_q[q0]; else r = '{1'b0, 3'd7, 24'hDEAD, 0};
            checks++;
            if (!w || got != exp || r.id !== exp[0] || r.st !== 3'd0) begin
                errors++; $display("FAIL grant_%0d: grant=%0d rsp_id=%0d st=%0d want %0d st0", n, got, r.id, r.st, exp);
            end
        end
        req0_valid = 0; req1_valid = 0;
        tick(GAP + 5);
    endtask

    task automatic test_stream;
        bit ok; rsp_t r; int st, s0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h08; bytes[1] = 8'h01; bytes[2] = 8'hFF;
        s0 = strm_q.size();
        for (int i = 0; i < 3; i++) send_rx(bytes[i]);
        tick(2);
        checks++;
        if (strm_q.size() - s0 != 3) begin
            errors++; $display("FAIL stream_count: got %0d want 3", strm_q.size() - s0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (strm_q[s0 + i] !== bytes[i]) begin
                    errors++; $display("FAIL stream_byte_%0d: got %h want %h", i, strm_q[s0 + i], bytes[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midcmd;
        bit w, ok; rsp_t r; int s0, q0, st;
        s0 = n_starts; q0 = rsp_q.size(); cur_cmd = 8'hED;
        raise(1'b0, 8'hED, 2'd1, w);
        if (w) wait_starts(s0 + 1, w);
        if (w) begin busy_pulse(1'b0); tick(2); end
        rst_n = 1'b0; tick();
        checks++;
        if ({req0_ready, req1_ready, tx_data, tx_start, rsp_valid, rsp_id, rsp_status, rsp_data,
             stream_valid, stream_byte, busy} !== '0) begin
            errors++; $display("FAIL midcmd_reset_outputs: outputs not all zero (busy=%b rsp_data=%h)", busy, rsp_data);
        end
        tick(); rst_n = 1'b1; tb_last = 1'b1; tick(TO + 20);
        checks++;
        if (!w || rsp_q.size() != q0) begin
            errors++; $display("FAIL midcmd_no_rsp: start_ok=%0b rsp_count=%0d want %0d", w, rsp_q.size() - q0, 0);
        end
        do_cmd(1'b1, 8'hF5, 2'd1, 0, 1'b0, 1'b0, 24'h0000C3, 1'b0, ok, r, st);
        checks++;
        if (!ok || r.id !== 1'b1 || r.st !== 3'd0 || r.d !== 24'h0000C3 || st != 1) begin
            errors++; $display("FAIL after_reset_cmd: ok=%0b id=%0d st=%0d d=%h starts=%0d", ok, r.id, r.st, r.d, st);
        end
    endtask

    task automatic test_random;
        bit ok, port, use_err, fc, stray; rsp_t r; int st, n_retry, s0, exp_starts, exp_strm;
        logic [7:0] cmd; logic [1:0] nresp; logic [23:0] pay, exp_d; logic [2:0] exp_st;
        for (int it = 0; it < 12; it++) begin
            port = 1'($urandom_range(0, 1)); cmd = 8'($urandom); nresp = 2'($urandom_range(0, 3));
            n_retry = $urandom_range(0, 4); use_err = 1'($urandom_range(0, 1));
            fc = ($urandom_range(0, 3) == 0); pay = 24'($urandom); stray = 1'($urandom_range(0, 1));
            exp_starts = (n_retry > MR) ? MR + 1 : n_retry + 1;
            exp_st = (n_retry > MR) ? 3'd3 : (fc ? 3'd1 : 3'd0);
            exp_d = '0;
            if (exp_st == 3'd0) for (int b = 0; b < int'(nresp); b++) exp_d[8*b +: 8] = pay[8*b +: 8];
            exp_strm = (n_retry <= MR && stray) ? 1 : 0;
            s0 = strm_q.size();
            do_cmd(port, cmd, nresp, n_retry, use_err, fc, pay, stray, ok, r, st);
            checks++;
            if (!ok || r.id !== port || r.st !== exp_st || r.d !== exp_d || st != exp_starts ||
                strm_q.size() - s0 != exp_strm) begin
                errors++;
                $display("FAIL random_%0d: ok=%0b id=%0d/%0d st=%0d/%0d d=%h/%h starts=%0d/%0d stream=%0d/%0d",
                         it, ok, r.id, port, r.st, exp_st, r.d, exp_d, st, exp_starts, strm_q.size() - s0, exp_strm);
            end
        end
        checks++;
        if (bad_tx != 0) begin errors++; $display("FAIL tx_data: %0d starts with wrong byte, want 0", bad_tx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_retry();
        test_timeout();
        test_back_to_back();
        test_stream();
        test_reset_midcmd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
